// File: rtl/systolic_feeder.sv
// Operand sequencer for the 2x2 systolic array. It latches one A/B matrix pair
// and replays them as diagonally skewed streams with per-diagonal push strobes.
module systolic_feeder #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                ready,
    input  logic [4*DATA_W-1:0] a_mat,
    input  logic [4*DATA_W-1:0] b_mat,
    output logic [DATA_W-1:0]   a1X,
    output logic [DATA_W-1:0]   a2X,
    output logic [DATA_W-1:0]   bX1,
    output logic [DATA_W-1:0]   bX2,
    output logic                push11,
    output logic                pushedge,
    output logic                push22,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4, DONE} state_e;

    state_e              state_q, state_d;
    logic [4*DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic                accept;

    logic [DATA_W-1:0]   a1X_q, a1X_d, a2X_q, a2X_d, bX1_q, bX1_d, bX2_q, bX2_d;
    logic                push11_q, push11_d, pushedge_q, pushedge_d, push22_q, push22_d;
    logic                busy_q, busy_d, done_q, done_d, ready_q, ready_d;

    assign accept = start && (state_q == IDLE);
    assign a_d    = accept ? a_mat : a_q;
    assign b_d    = accept ? b_mat : b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = S0;
            S0:      state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = S4;
            S4:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and next operands, then registered,
    // so each value lines up with the cycle in which its state is current.
    always_comb begin
        a1X_d      = '0;
        a2X_d      = '0;
        bX1_d      = '0;
        bX2_d      = '0;
        push11_d   = 1'b0;
        pushedge_d = 1'b0;
        push22_d   = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d != IDLE);
        ready_d    = (state_d == IDLE);
        case (state_d)
            S0: begin
                a1X_d = a_d[0*DATA_W +: DATA_W];
                bX1_d = b_d[0*DATA_W +: DATA_W];
            end
            S1: begin
                a1X_d = a_d[1*DATA_W +: DATA_W];
                a2X_d = a_d[2*DATA_W +: DATA_W];
                bX1_d = b_d[2*DATA_W +: DATA_W];
                bX2_d = b_d[1*DATA_W +: DATA_W];
            end
            S2: begin
                a2X_d    = a_d[3*DATA_W +: DATA_W];
                bX2_d    = b_d[3*DATA_W +: DATA_W];
                push11_d = 1'b1;
            end
            S3:      pushedge_d = 1'b1;
            S4:      push22_d   = 1'b1;
            DONE:    done_d     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a1X_q      <= '0;
            a2X_q      <= '0;
            bX1_q      <= '0;
            bX2_q      <= '0;
            push11_q   <= 1'b0;
            pushedge_q <= 1'b0;
            push22_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            a1X_q      <= a1X_d;
            a2X_q      <= a2X_d;
            bX1_q      <= bX1_d;
            bX2_q      <= bX2_d;
            push11_q   <= push11_d;
            pushedge_q <= pushedge_d;
            push22_q   <= push22_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign a1X      = a1X_q;
    assign a2X      = a2X_q;
    assign bX1      = bX1_q;
    assign bX2      = bX2_q;
    assign push11   = push11_q;
    assign pushedge = pushedge_q;
    assign push22   = push22_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: hand-computed stream/strobe vectors
// checked each cycle at the falling clock edge.
module tb_systolic_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic [4*W-1:0] a_mat, b_mat;
    logic [W-1:0] a1X, a2X, bX1, bX2;
    logic         push11, pushedge, push22, busy, done;

    int tests = 0;
    int fails = 0;

    systolic_feeder #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .a_mat(a_mat), .b_mat(b_mat),
        .a1X(a1X), .a2X(a2X), .bX1(bX1), .bX2(bX2),
        .push11(push11), .pushedge(pushedge), .push22(push22),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [4*W-1:0] mat(input int x11, input int x12, input int x21, input int x22);
        return {W'(x22), W'(x21), W'(x12), W'(x11)};
    endfunction

    // {ready,busy,done,push11,pushedge,push22,a1X,a2X,bX1,bX2}
    function automatic logic [6+4*W-1:0] ex(input bit r, input bit b, input bit d,
                                            input bit p11, input bit pe, input bit p22,
                                            input int a1, input int a2, input int b1, input int b2);
        return {r, b, d, p11, pe, p22, W'(a1), W'(a2), W'(b1), W'(b2)};
    endfunction

    task automatic chk(input string tag, input logic [6+4*W-1:0] expv);
        logic [6+4*W-1:0] obs;
        obs = {ready, busy, done, push11, pushedge, push22, a1X, a2X, bX1, bX2};
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Entered with S0 current; leaves with DONE current.
    task automatic run_seq(input string tag,
                           input int a11, input int a12, input int a21, input int a22,
                           input int b11, input int b12, input int b21, input int b22,
                           input bit poke);
        chk({tag, "_S0"}, ex(0, 1, 0, 0, 0, 0, a11, 0, b11, 0));
        tick();
        chk({tag, "_S1"}, ex(0, 1, 0, 0, 0, 0, a12, a21, b21, b12));
        if (poke) begin
            start = 1'b1;
            a_mat = mat(85, 85, 85, 85);
        end
        tick();
        if (poke) start = 1'b0;
        chk({tag, "_S2"}, ex(0, 1, 0, 1, 0, 0, 0, a22, 0, b22));
        tick();
        chk({tag, "_S3"}, ex(0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        chk({tag, "_S4"}, ex(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tick();
        chk({tag, "_DONE"}, ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a_mat = '0;
        b_mat = '0;
        tick();
        tick();
        chk_idle("reset_state");
        reset = 1'b0;
        tick();
        chk_idle("post_reset");

        // Mixed-sign operands
        a_mat = mat(-6, 7, 1, -4);
        b_mat = mat(-2, 0, 9, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_seq("t1", -6, 7, 1, -4, -2, 0, 9, 1, 1'b0);
        tick();
        chk_idle("t1_idle");

        // Extremes must pass bit-exact
        a_mat = mat(-128, -128, -128, -128);
        b_mat = mat(127, 127, 127, 127);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_seq("t2", -128, -128, -128, -128, 127, 127, 127, 127, 1'b0);
        tick();
        chk_idle("t2_idle");

        // start during S1 with new a_mat is ignored
        a_mat = mat(-6, 7, 1, -4);
        b_mat = mat(-2, 0, 9, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_seq("t3", -6, 7, 1, -4, -2, 0, 9, 1, 1'b1);
        tick();
        chk_idle("t3_idle");
        tick();
        chk_idle("t3_no_rerun");

        // start held high: two sequences, one IDLE cycle between
        a_mat = mat(-6, 7, 1, -4);
        b_mat = mat(-2, 0, 9, 1);
        start = 1'b1;
        tick();
        a_mat = mat(3, -1, 2, 5);
        b_mat = mat(4, -3, -7, 8);
        run_seq("t4a", -6, 7, 1, -4, -2, 0, 9, 1, 1'b0);
        tick();
        chk_idle("t4_gap");
        tick();
        start = 1'b0;
        run_seq("t4b", 3, -1, 2, 5, 4, -3, -7, 8, 1'b0);
        tick();
        chk_idle("t4_idle");

        // Reset in S2 abandons the sequence
        a_mat = mat(-6, 7, 1, -4);
        b_mat = mat(-2, 0, 9, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_S0", ex(0, 1, 0, 0, 0, 0, -6, 0, -2, 0));
        tick();
        tick();
        chk("t5_S2", ex(0, 1, 0, 1, 0, 0, 0, -4, 0, 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("t5_reset");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle("t5_no_push22_done");
        end

        // Long idle with no start
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle("t6_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
